dac_wavegen: RTL and testbench

Parametrised waveform source that drives the `dac_val`/`val_req` input of the R2R+PWM DAC core. It replaces the fixed hard-coded triangle generator with a runtime-configurable engine. Modes are HOLD, SAWTOOTH, TRIANGLE and SQUARE, with programmable min/max bounds, step size and sample-rate divider. Bounds are exact: the output never overshoots `max_val` or undershoots `min_val`.

---
 rtl/dac_wavegen.sv | 147 ++++++++++++++
 tb/tb_dac_wavegen.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_wavegen.sv
// Runtime-configurable waveform source feeding the DAC core's dac_val/val_req port.
// Supports HOLD, SAWTOOTH, TRIANGLE and SQUARE with exact min/max bounds.
module dac_wavegen #(
  parameter int DAC_BITS  = 14,
  parameter int STEP_BITS = 8,
  parameter int DIV_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [1:0]           cfg_mode,
  input  logic [DAC_BITS-1:0]  cfg_min,
  input  logic [DAC_BITS-1:0]  cfg_max,
  input  logic [STEP_BITS-1:0] cfg_step,
  input  logic [DIV_BITS-1:0]  cfg_div,
  input  logic                 val_req,
  output logic [DAC_BITS-1:0]  dac_val,
  output logic                 dir,
  output logic                 cycle,
  output logic                 cfg_err
);

  localparam int EW = DAC_BITS + 1;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_t;

  mode_t                mode_q;
  logic [DAC_BITS-1:0]  min_q;
  logic [DAC_BITS-1:0]  max_q;
  logic [STEP_BITS-1:0] step_q;
  logic [DIV_BITS-1:0]  div_q;
  logic [DIV_BITS-1:0]  div_cnt;
  logic                 sq_high;

  logic [EW-1:0]        s_ext;
  logic [EW-1:0]        v_ext;
  logic [EW-1:0]        min_ext;
  logic [EW-1:0]        max_ext;
  logic [EW-1:0]        sum;
  logic [DAC_BITS-1:0]  nxt_val;
  logic                 nxt_dir;
  logic                 nxt_cycle;
  logic                 nxt_sq;

  // Next sample for one advance; one extra bit keeps v+s and min+s from wrapping.
  // SQUARE tracks its phase explicitly so min == max still yields a period of two.
  always_comb begin
    s_ext     = (step_q == '0) ? EW'(1) : EW'(step_q);
    v_ext     = {1'b0, dac_val};
    min_ext   = {1'b0, min_q};
    max_ext   = {1'b0, max_q};
    sum       = v_ext + s_ext;
    nxt_val   = dac_val;
    nxt_dir   = 1'b0;
    nxt_cycle = 1'b0;
    nxt_sq    = sq_high;
    case (mode_q)
      MODE_HOLD: nxt_val = min_q;
      MODE_SAW: begin
        if (sum > max_ext) begin
          nxt_val   = min_q;
          nxt_cycle = 1'b1;
        end else begin
          nxt_val = sum[DAC_BITS-1:0];
        end
      end
      MODE_TRI: begin
        if (!dir) begin
          if (sum >= max_ext) begin
            nxt_val = max_q;
            nxt_dir = 1'b1;
          end else begin
            nxt_val = sum[DAC_BITS-1:0];
          end
        end else if (v_ext < min_ext + s_ext) begin
          nxt_val   = min_q;
          nxt_cycle = 1'b1;
        end else begin
          nxt_val = dac_val - s_ext[DAC_BITS-1:0];
          nxt_dir = 1'b1;
        end
      end
      MODE_SQUARE: begin
        if (!sq_high) begin
          nxt_val = max_q;
          nxt_sq  = 1'b1;
        end else begin
          nxt_val   = min_q;
          nxt_sq    = 1'b0;
          nxt_cycle = 1'b1;
        end
      end
      default: nxt_val = dac_val;
    endcase
  end

  // A load (accepted or rejected) swallows a coincident val_req.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_HOLD;
      min_q   <= '0;
      max_q   <= '1;
      step_q  <= STEP_BITS'(1);
      div_q   <= '0;
      div_cnt <= '0;
      sq_high <= 1'b0;
      dac_val <= '0;
      dir     <= 1'b0;
      cycle   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cycle   <= 1'b0;
      cfg_err <= 1'b0;
      if (cfg_load) begin
        if (cfg_min <= cfg_max) begin
          mode_q  <= mode_t'(cfg_mode);
          min_q   <= cfg_min;
          max_q   <= cfg_max;
          step_q  <= cfg_step;
          div_q   <= cfg_div;
          div_cnt <= '0;
          sq_high <= 1'b0;
          dac_val <= cfg_min;
          dir     <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (val_req) begin
        if (div_cnt == div_q) begin
          div_cnt <= '0;
          dac_val <= nxt_val;
          dir     <= nxt_dir;
          cycle   <= nxt_cycle;
          sq_high <= nxt_sq;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_wavegen.sv
// Self-checking bench for dac_wavegen: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the waveform rules.
module tb_dac_wavegen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_load = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic [13:0] cfg_min = '0;
  logic [13:0] cfg_max = '0;
  logic [7:0]  cfg_step = '0;
  logic [7:0]  cfg_div = '0;
  logic        val_req = 1'b0;
  logic [13:0] dac_val;
  logic        dir;
  logic        cycle;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_val, m_dir, m_cnt, m_sq;
  int c_mode, c_min, c_max, c_step, c_div;
  bit e_cycle, e_err;

  dac_wavegen #(.DAC_BITS(14), .STEP_BITS(8), .DIV_BITS(8)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_step(cfg_step), .cfg_div(cfg_div),
    .val_req(val_req), .dac_val(dac_val), .dir(dir), .cycle(cycle), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic model_advance();
    int s;
    s = (c_step == 0) ? 1 : c_step;
    case (c_mode)
      0: m_val = c_min;
      1: if (m_val + s > c_max) begin m_val = c_min; e_cycle = 1; end
         else m_val = m_val + s;
      2: if (m_dir == 0) begin
           if (m_val + s >= c_max) begin m_val = c_max; m_dir = 1; end
           else m_val = m_val + s;
         end else if (m_val - s < c_min) begin
           m_val = c_min; m_dir = 0; e_cycle = 1;
         end else m_val = m_val - s;
      default: begin
        m_sq = m_sq + 1;
        m_val = (m_sq % 2 == 1) ? c_max : c_min;
        if (m_sq % 2 == 0) e_cycle = 1;
      end
    endcase
  endtask

  task automatic model_step(input bit r, input bit ld, input bit rq);
    e_cycle = 0;
    e_err = 0;
    if (r) begin
      m_val = 0; m_dir = 0; m_cnt = 0; m_sq = 0;
      c_mode = 0; c_min = 0; c_max = 16383; c_step = 1; c_div = 0;
    end else if (ld) begin
      if (cfg_min <= cfg_max) begin
        c_mode = int'(cfg_mode); c_min = int'(cfg_min); c_max = int'(cfg_max);
        c_step = int'(cfg_step); c_div = int'(cfg_div);
        m_val = c_min; m_dir = 0; m_cnt = 0; m_sq = 0;
      end else e_err = 1;
    end else if (rq) begin
      if (m_cnt == c_div) begin m_cnt = 0; model_advance(); end
      else m_cnt = m_cnt + 1;
    end
  endtask

  // Apply inputs for one clock edge, update the model, and return at the next negedge.
  task automatic clock_in(input bit r, input bit ld, input bit rq);
    rst = r; cfg_load = ld; val_req = rq;
    @(posedge clk);
    model_step(r, ld, rq);
    @(negedge clk);
    rst = 0; cfg_load = 0; val_req = 0;
  endtask

  task automatic set_cfg(input int mode, input int mn, input int mx, input int st, input int dv);
    cfg_mode = 2'(mode); cfg_min = 14'(mn); cfg_max = 14'(mx);
    cfg_step = 8'(st); cfg_div = 8'(dv);
  endtask

  task automatic test_reset();
    clock_in(1, 0, 0);
    checks++;
    if ({dac_val, dir, cycle, cfg_err} !== 17'd0) begin
      errors++; $display("[TB] FAIL reset_outputs: got val=%0d dir=%b cyc=%b err=%b want all 0", dac_val, dir, cycle, cfg_err);
    end
    for (int i = 0; i < 4; i++) begin
      clock_in(0, 0, 1);
      checks++;
      if (dac_val !== 14'd0 || cycle !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_hold[%0d]: got val=%0d cyc=%b want 0/0", i, dac_val, cycle);
      end
      clock_in(0, 0, 0);
    end
  endtask

  task automatic test_sawtooth();
    int tv[3] = '{14, 18, 10};
    bit tc[3] = '{0, 0, 1};
    set_cfg(1, 10, 20, 4, 0);
    clock_in(0, 1, 0);
    checks++;
    if (dac_val !== 14'd10) begin
      errors++; $display("[TB] FAIL saw_load: got %0d want 10", dac_val);
    end
    for (int i = 0; i < 3; i++) begin
      clock_in(0, 0, 1);
      checks++;
      if (dac_val !== 14'(tv[i]) || cycle !== tc[i] || dac_val !== 14'(m_val)) begin
        errors++; $display("[TB] FAIL saw_seq[%0d]: got val=%0d cyc=%b want val=%0d cyc=%b", i, dac_val, cycle, tv[i], tc[i]);
      end
      clock_in(0, 0, 0);
      checks++;
      if (cycle !== 1'b0) begin
        errors++; $display("[TB] FAIL saw_cycle_width[%0d]: got %b want 0", i, cycle);
      end
    end
  endtask

  task automatic test_triangle();
    int tv[8] = '{103, 106, 109, 110, 107, 104, 101, 100};
    bit td[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    bit tc[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    set_cfg(2, 100, 110, 3, 0);
    clock_in(0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      clock_in(0, 0, 1);
      checks++;
      if (dac_val !== 14'(tv[i]) || dir !== td[i] || cycle !== tc[i]) begin
        errors++; $display("[TB] FAIL tri_seq[%0d]: got val=%0d dir=%b cyc=%b want val=%0d dir=%b cyc=%b",
                           i, dac_val, dir, cycle, tv[i], td[i], tc[i]);
      end
      clock_in(0, 0, 0);
    end
  endtask

  task automatic test_square();
    set_cfg(3, 0, 16383, 1, 2);
    clock_in(0, 1, 0);
    for (int i = 1; i <= 9; i++) begin
      int ev;
      bit ec;
      ev = ((i / 3) % 2 == 1) ? 16383 : 0;
      ec = (i == 6);
      clock_in(0, 0, 1);
      checks++;
      if (dac_val !== 14'(ev) || cycle !== ec) begin
        errors++; $display("[TB] FAIL square_seq[%0d]: got val=%0d cyc=%b want val=%0d cyc=%b", i, dac_val, cycle, ev, ec);
      end
      clock_in(0, 0, 0);
    end
  endtask

  task automatic test_cfg_err();
    set_cfg(2, 100, 110, 3, 0);
    clock_in(0, 1, 0);
    clock_in(0, 0, 1); clock_in(0, 0, 0);
    clock_in(0, 0, 1); clock_in(0, 0, 0);
    set_cfg(1, 50, 40, 9, 5);
    clock_in(0, 1, 0);
    checks++;
    if (cfg_err !== 1'b1 || dac_val !== 14'd106 || dir !== 1'b0) begin
      errors++; $display("[TB] FAIL cfg_err_pulse: got err=%b val=%0d dir=%b want 1/106/0", cfg_err, dac_val, dir);
    end
    clock_in(0, 0, 0);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("[TB] FAIL cfg_err_width: got %b want 0", cfg_err);
    end
    for (int i = 0; i < 3; i++) begin
      clock_in(0, 0, 1);
      checks++;
      if (dac_val !== 14'(m_val) || dir !== m_dir[0]) begin
        errors++; $display("[TB] FAIL cfg_err_continue[%0d]: got val=%0d dir=%b want val=%0d dir=%0d", i, dac_val, dir, m_val, m_dir);
      end
      clock_in(0, 0, 0);
    end
  endtask

  task automatic test_degenerate();
    bit cyc_tbl[3][4] = '{'{1, 1, 1, 1}, '{0, 1, 0, 1}, '{0, 1, 0, 1}};
    for (int m = 1; m <= 3; m++) begin
      set_cfg(m, 500, 500, 5, 0);
      clock_in(0, 1, 0);
      for (int i = 0; i < 4; i++) begin
        bit ed;
        ed = (m == 2) && (i % 2 == 0);
        clock_in(0, 0, 1);
        checks++;
        if (dac_val !== 14'd500 || cycle !== cyc_tbl[m-1][i] || dir !== ed) begin
          errors++; $display("[TB] FAIL degenerate[m%0d,%0d]: got val=%0d cyc=%b dir=%b want 500/%b/%b",
                             m, i, dac_val, cycle, dir, cyc_tbl[m-1][i], ed);
        end
        clock_in(0, 0, 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(1, 0, 100, 7, 0);
    clock_in(0, 1, 0);
    for (int i = 0; i < 18; i++) begin
      clock_in(0, 0, 1);
      checks++;
      if (dac_val !== 14'(m_val) || cycle !== e_cycle) begin
        errors++; $display("[TB] FAIL back_to_back[%0d]: got val=%0d cyc=%b want val=%0d cyc=%b", i, dac_val, cycle, m_val, e_cycle);
      end
    end
  endtask

  task automatic test_collision_and_reset();
    set_cfg(1, 0, 1000, 10, 1);
    clock_in(0, 1, 0);
    for (int i = 0; i < 4; i++) begin clock_in(0, 0, 1); clock_in(0, 0, 0); end
    checks++;
    if (dac_val !== 14'd20) begin
      errors++; $display("[TB] FAIL collide_pre: got %0d want 20", dac_val);
    end
    set_cfg(1, 300, 900, 10, 1);
    clock_in(0, 1, 1);
    checks++;
    if (dac_val !== 14'd300) begin
      errors++; $display("[TB] FAIL collide_load: got %0d want 300", dac_val);
    end
    clock_in(0, 0, 0);
    clock_in(0, 0, 1);
    checks++;
    if (dac_val !== 14'd300) begin
      errors++; $display("[TB] FAIL collide_div_first: got %0d want 300", dac_val);
    end
    clock_in(0, 0, 0);
    clock_in(0, 0, 1);
    checks++;
    if (dac_val !== 14'd310) begin
      errors++; $display("[TB] FAIL collide_div_second: got %0d want 310", dac_val);
    end
    clock_in(0, 0, 0);
    set_cfg(2, 5000, 6000, 50, 0);
    clock_in(1, 1, 1);
    checks++;
    if ({dac_val, dir, cycle, cfg_err} !== 17'd0) begin
      errors++; $display("[TB] FAIL reset_override: got val=%0d dir=%b cyc=%b err=%b want all 0", dac_val, dir, cycle, cfg_err);
    end
    clock_in(0, 0, 1);
    checks++;
    if (dac_val !== 14'd0 || cycle !== 1'b0 || dir !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_config_hold: got val=%0d cyc=%b dir=%b want 0/0/0", dac_val, cycle, dir);
    end
    clock_in(0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      bit r, ld, rq;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 99) < 3);
      rq = ($urandom_range(0, 99) < 40);
      if (ld) begin
        int a, b, t;
        if ($urandom_range(0, 1) == 0) begin
          a = $urandom_range(0, 16383);
          b = a + $urandom_range(0, 300);
          if (b > 16383) b = 16383;
        end else begin
          a = $urandom_range(0, 16383);
          b = $urandom_range(0, 16383);
          if (a > b) begin t = a; a = b; b = t; end
        end
        if ($urandom_range(0, 9) == 0 && a != b) begin t = a; a = b; b = t; end
        set_cfg($urandom_range(0, 3), a, b, $urandom_range(0, 255), $urandom_range(0, 3));
      end
      clock_in(r, ld, rq);
      checks++;
      if (dac_val !== 14'(m_val) || dir !== m_dir[0] || cycle !== e_cycle || cfg_err !== e_err) begin
        errors++; $display("[TB] FAIL random[%0d]: got val=%0d dir=%b cyc=%b err=%b want val=%0d dir=%0d cyc=%b err=%b",
                           n, dac_val, dir, cycle, cfg_err, m_val, m_dir, e_cycle, e_err);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sawtooth();
    test_triangle();
    test_square();
    test_cfg_err();
    test_degenerate();
    test_back_to_back();
    test_collision_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
